// File: rtl/scope_acq_sequencer.sv
// Acquisition sequencer: shares the SPI engine between amp gain loads and paced ADC conversions.
// Define SCOPE_ACQ_TIMEOUT_EN to add an 8-bit watchdog on conversions and gain writes.
module scope_acq_sequencer #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic [DIV_W-1:0] rate_div,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [7:0]       gain,
    input  logic             gain_load,
    output logic             amp_start,
    output logic [7:0]       amp_gain,
    input  logic             amp_busy,
    output logic             conv_start,
    input  logic             conv_done,
    input  logic [13:0]      sample,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GAIN      = 3'd1;
    localparam logic [2:0] S_GAIN_WAIT = 3'd2;
    localparam logic [2:0] S_TICK_WAIT = 3'd3;
    localparam logic [2:0] S_CONV_WAIT = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             pend_q, pend_d;
    logic [7:0]       pend_gain_q, pend_gain_d;
    logic [7:0]       amp_gain_q, amp_gain_d;
    logic             amp_start_q, amp_start_d;
    logic             conv_start_q, conv_start_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic running;
    logic tick;
    logic accept;
    logic wr_ok;
    logic abortable;
    logic wd_expire;

    always_comb begin
        running   = (state_q == S_TICK_WAIT) || (state_q == S_CONV_WAIT);
        tick      = running && (timer_q == '0);
        accept    = out_valid_q && out_ready;
        // A full register being drained this cycle can take a new word.
        wr_ok     = !out_valid_q || out_ready;
        abortable = running || (state_q == S_DRAIN);
    end

`ifdef SCOPE_ACQ_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;

    always_comb begin
        wd_expire = (wdog_q == 8'hFF) &&
                    (((state_q == S_CONV_WAIT) && !conv_done) ||
                     ((state_q == S_GAIN_WAIT) && amp_busy));
    end
`else
    always_comb begin
        wd_expire = 1'b0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rate_d      = rate_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        pend_d      = pend_q;
        pend_gain_d = pend_gain_q;
        amp_gain_d  = amp_gain_q;
        out_valid_d = out_valid_q && !accept;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        if (gain_load) begin
            pend_d      = 1'b1;
            pend_gain_d = gain;
        end

        if (running) begin
            timer_d = tick ? rate_q : (timer_q - DIV_W'(1));
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q || gain_load) begin
                    state_d    = S_GAIN;
                    pend_d     = 1'b0;
                    amp_gain_d = gain_load ? gain : pend_gain_q;
                end else if (arm && (num_samples != '0)) begin
                    rate_d    = rate_div;
                    cnt_d     = num_samples;
                    timer_d   = '0;
                    first_d   = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = S_TICK_WAIT;
                end
            end
            S_GAIN: begin
                state_d = S_GAIN_WAIT;
            end
            S_GAIN_WAIT: begin
                if (!amp_busy) begin
                    state_d = S_IDLE;
                end else if (wd_expire) begin
                    state_d   = S_IDLE;
                    overrun_d = 1'b1;
                end
            end
            S_TICK_WAIT: begin
                if (tick) begin
                    state_d = S_CONV_WAIT;
                end
            end
            S_CONV_WAIT: begin
                // A slot that elapses while a conversion is still out is lost.
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (conv_done) begin
                    if (wr_ok) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {first_q, 1'b0, sample};
                    end else begin
                        overrun_d = 1'b1;
                    end
                    first_d = 1'b0;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? S_DRAIN : S_TICK_WAIT;
                end else if (wd_expire) begin
                    state_d   = S_IDLE;
                    overrun_d = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && abortable) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end

        if ((state_d == S_DRAIN) && !out_valid_d) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
        end

        // Strobes are registered against the next state so they line up with the state they belong to.
        conv_start_d = (state_d == S_TICK_WAIT) && (timer_d == '0);
        amp_start_d  = (state_d == S_GAIN);
        busy_d       = (state_d != S_IDLE);
    end

`ifdef SCOPE_ACQ_TIMEOUT_EN
    always_comb begin
        wdog_d = wdog_q;
        if (conv_start_d || amp_start_d) begin
            wdog_d = '0;
        end else if (((state_q == S_CONV_WAIT) || (state_q == S_GAIN_WAIT)) && (wdog_q != 8'hFF)) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            rate_q       <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_gain_q  <= '0;
            amp_gain_q   <= '0;
            amp_start_q  <= 1'b0;
            conv_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rate_q       <= rate_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            pend_q       <= pend_d;
            pend_gain_q  <= pend_gain_d;
            amp_gain_q   <= amp_gain_d;
            amp_start_q  <= amp_start_d;
            conv_start_q <= conv_start_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign amp_start  = amp_start_q;
    assign amp_gain   = amp_gain_q;
    assign conv_start = conv_start_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_scope_acq_sequencer.sv
// Directed bench for scope_acq_sequencer: cycle-scheduled ADC/amp responders and hand-computed expectations.
module tb_scope_acq_sequencer;

    localparam int DIV_W = 16;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic [DIV_W-1:0] rate_div = '0;
    logic [CNT_W-1:0] num_samples = '0;
    logic [7:0]       gain = '0;
    logic             gain_load = 1'b0;
    logic             amp_start;
    logic [7:0]       amp_gain;
    logic             amp_busy = 1'b0;
    logic             conv_start;
    logic             conv_done = 1'b0;
    logic [13:0]      sample = '0;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             overrun;

    scope_acq_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .rate_div    (rate_div),
        .num_samples (num_samples),
        .gain        (gain),
        .gain_load   (gain_load),
        .amp_start   (amp_start),
        .amp_gain    (amp_gain),
        .amp_busy    (amp_busy),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .sample      (sample),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scenario schedule, in cycles counted from the start of run_cycles.
    int         arm_at, gain_at, abort_at, ready_from, lat, amp_len;
    logic [7:0] gain_val;

    // Observations gathered by run_cycles.
    int          conv_cnt, word_cnt, done_cnt, done_t, amp_cnt, amp_t, busy_cnt, gbad;
    int          conv_t[8];
    logic [15:0] words[8];
    int          cd_at, cd_idx, amp_lo, amp_hi;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic clear_sched();
        arm_at = -1; gain_at = -1; abort_at = -1; ready_from = 0; lat = 3; amp_len = 20;
        gain_val = 8'h00;
        conv_cnt = 0; word_cnt = 0; done_cnt = 0; done_t = -1; amp_cnt = 0; amp_t = -1;
        busy_cnt = 0; gbad = 0; cd_at = -1; cd_idx = 0; amp_lo = -1; amp_hi = -2;
        for (int i = 0; i < 8; i++) begin
            conv_t[i] = -1;
            words[i]  = 16'hxxxx;
        end
    endtask

    task automatic run_cycles(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (conv_start) begin
                if (conv_cnt < 8) conv_t[conv_cnt] = k;
                conv_cnt++;
                cd_at = k + lat;
            end
            if (amp_start) begin
                amp_t  = k;
                amp_cnt++;
                amp_lo = k + 1;
                amp_hi = k + amp_len;
            end
            if (amp_cnt > 0 && k <= amp_hi && amp_gain !== gain_val) gbad++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_t = k;
            end
            arm       = (k == arm_at);
            gain_load = (k == gain_at);
            gain      = gain_val;
            abort     = (k == abort_at);
            out_ready = (k >= ready_from);
            amp_busy  = (k >= amp_lo) && (k <= amp_hi);
            conv_done = (k == cd_at);
            if (conv_done) begin
                sample = 14'h0A00 + 14'(cd_idx);
                cd_idx++;
            end
            if (out_valid && out_ready) begin
                if (word_cnt < 8) words[word_cnt] = out_data;
                word_cnt++;
            end
            @(posedge clk); #1;
        end
        arm = 1'b0; gain_load = 1'b0; abort = 1'b0; conv_done = 1'b0; amp_busy = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        check_val("rst_amp_start", 32'(amp_start), 32'd0);
        check_val("rst_amp_gain", 32'(amp_gain), 32'h00);
        check_val("rst_conv_start", 32'(conv_start), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'h0000);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);

        // Nominal capture, downstream always ready.
        clear_sched();
        rate_div = 16'd9; num_samples = 10'd4; arm_at = 0;
        run_cycles(45);
        check_val("a_conv_cnt", 32'(conv_cnt), 32'd4);
        check_val("a_conv_t0", 32'(conv_t[0]), 32'd1);
        check_val("a_conv_t1", 32'(conv_t[1]), 32'd11);
        check_val("a_conv_t2", 32'(conv_t[2]), 32'd21);
        check_val("a_conv_t3", 32'(conv_t[3]), 32'd31);
        check_val("a_word_cnt", 32'(word_cnt), 32'd4);
        check_val("a_word0", 32'(words[0]), 32'h8A00);
        check_val("a_word1", 32'(words[1]), 32'h0A01);
        check_val("a_word3", 32'(words[3]), 32'h0A03);
        check_val("a_done_cnt", 32'(done_cnt), 32'd1);
        check_val("a_done_t", 32'(done_t), 32'd36);
        check_val("a_busy_cnt", 32'(busy_cnt), 32'd35);
        check_val("a_overrun", 32'(overrun), 32'd0);

        // Same capture with downstream stalled until cycle 40.
        clear_sched();
        rate_div = 16'd9; num_samples = 10'd4; arm_at = 0; ready_from = 40;
        run_cycles(50);
        check_val("b_conv_cnt", 32'(conv_cnt), 32'd4);
        check_val("b_word_cnt", 32'(word_cnt), 32'd1);
        check_val("b_word0", 32'(words[0]), 32'h8A00);
        check_val("b_overrun", 32'(overrun), 32'd1);
        check_val("b_done_cnt", 32'(done_cnt), 32'd1);
        check_val("b_done_t", 32'(done_t), 32'd41);

        // Conversion slower than the rate: skipped slots.
        clear_sched();
        rate_div = 16'd2; num_samples = 10'd3; arm_at = 0; lat = 5;
        run_cycles(30);
        check_val("c_conv_cnt", 32'(conv_cnt), 32'd3);
        check_val("c_conv_t1", 32'(conv_t[1]), 32'd7);
        check_val("c_conv_t2", 32'(conv_t[2]), 32'd13);
        check_val("c_word_cnt", 32'(word_cnt), 32'd3);
        check_val("c_word0", 32'(words[0]), 32'h8A00);
        check_val("c_word2", 32'(words[2]), 32'h0A02);
        check_val("c_done_t", 32'(done_t), 32'd20);
        check_val("c_overrun", 32'(overrun), 32'd1);

        // Gain load in IDLE.
        clear_sched();
        gain_at = 0; gain_val = 8'h11;
        run_cycles(30);
        check_val("d_amp_cnt", 32'(amp_cnt), 32'd1);
        check_val("d_amp_t", 32'(amp_t), 32'd1);
        check_val("d_gain_bad", 32'(gbad), 32'd0);
        check_val("d_amp_gain", 32'(amp_gain), 32'h11);
        check_val("d_busy_cnt", 32'(busy_cnt), 32'd22);
        check_val("d_conv_cnt", 32'(conv_cnt), 32'd0);

        // Gain load during a capture is deferred until after done.
        clear_sched();
        rate_div = 16'd9; num_samples = 10'd2; arm_at = 0; gain_at = 5; gain_val = 8'h5A;
        run_cycles(50);
        check_val("e_done_cnt", 32'(done_cnt), 32'd1);
        check_val("e_done_t", 32'(done_t), 32'd16);
        check_val("e_amp_cnt", 32'(amp_cnt), 32'd1);
        check_val("e_amp_t", 32'(amp_t), 32'd17);
        check_val("e_gain_bad", 32'(gbad), 32'd0);
        check_val("e_busy_end", 32'(busy), 32'd0);

        // Abort mid-capture, late conv_done ignored.
        clear_sched();
        rate_div = 16'd9; num_samples = 10'd4; arm_at = 0; ready_from = 1000; abort_at = 12;
        run_cycles(40);
        check_val("f_conv_cnt", 32'(conv_cnt), 32'd2);
        check_val("f_busy_cnt", 32'(busy_cnt), 32'd12);
        check_val("f_done_cnt", 32'(done_cnt), 32'd0);
        check_val("f_out_valid", 32'(out_valid), 32'd0);
        check_val("f_overrun", 32'(overrun), 32'd0);

        // Gain load and arm in the same cycle: gain wins, arm dropped.
        clear_sched();
        rate_div = 16'd9; num_samples = 10'd3; arm_at = 0; gain_at = 0; gain_val = 8'h22;
        run_cycles(30);
        check_val("g_amp_cnt", 32'(amp_cnt), 32'd1);
        check_val("g_amp_t", 32'(amp_t), 32'd1);
        check_val("g_conv_cnt", 32'(conv_cnt), 32'd0);
        check_val("g_done_cnt", 32'(done_cnt), 32'd0);

        // Arm with zero samples is ignored.
        clear_sched();
        rate_div = 16'd3; num_samples = 10'd0; arm_at = 0;
        run_cycles(6);
        check_val("h_conv_cnt", 32'(conv_cnt), 32'd0);
        check_val("h_busy_cnt", 32'(busy_cnt), 32'd0);

        // Asynchronous reset mid-capture with a full holding register.
        clear_sched();
        rate_div = 16'd9; num_samples = 10'd4; arm_at = 0; ready_from = 1000;
        run_cycles(20);
        check_val("i_pre_out_valid", 32'(out_valid), 32'd1);
        check_val("i_pre_overrun", 32'(overrun), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("i_out_valid", 32'(out_valid), 32'd0);
        check_val("i_out_data", 32'(out_data), 32'h0000);
        check_val("i_busy", 32'(busy), 32'd0);
        check_val("i_overrun", 32'(overrun), 32'd0);
        check_val("i_conv_start", 32'(conv_start), 32'd0);
        check_val("i_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_sched();
        run_cycles(12);
        check_val("i_post_conv_cnt", 32'(conv_cnt), 32'd0);
        check_val("i_post_busy_cnt", 32'(busy_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scope_acq_sequencer.md
# scope_acq_sequencer

Acquisition sequencer for the scope front end. It arbitrates the shared SPI engine between programmable-amplifier gain loads and ADC conversions. It also paces conversions from a programmable clock divider, counts the samples in each capture and buffers each sample in a one-entry holding register for the downstream byte splitter/UART path. It sits between the top-level control and the ADC/amp SPI engine, upstream of the register splitter.

## Interface
Parameters:
- DIV_W, 16, width of conversion-period divider
- CNT_W, 10, width of per-capture sample counter

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-low.
- arm  in  1  one-cycle pulse: start a capture.
- abort  in  1  one-cycle pulse: stop the capture.
- rate_div  in  DIV_W  conversion period minus 1, in clk cycles; sampled at arm.
- num_samples  in  CNT_W  samples per capture; sampled at arm.
- gain  in  8  amp gain {B[3:0],A[3:0]}; sampled at gain_load.
- gain_load  in  1  pulse: request a gain reprogram.
- amp_start  out  1  pulse: SPI engine starts a gain write.
- amp_gain  out  8  gain byte, held stable from amp_start until amp_busy falls.
- amp_busy  in  1  SPI engine gain write in progress.
- conv_start  out  1  pulse: SPI engine starts a conversion.
- conv_done  in  1  pulse: sample valid.
- sample  in  14  ADC channel-A result; valid only with conv_done.
- out_valid  out  1  holding register full.
- out_data  out  16  {first_flag, 1'b0, sample[13:0]}.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  state != IDLE.
- done  out  1  pulse: capture complete.
- overrun  out  1  sticky error flag.

## Operation
- States: IDLE, GAIN, GAIN_WAIT, TICK_WAIT, CONV_WAIT, DRAIN.
- IDLE: if gain_load is pending, go to GAIN. Otherwise, on arm with num_samples != 0: latch rate_div/num_samples, load timer to 0, clear overrun, go to TICK_WAIT. Ignore arm when num_samples == 0.
- gain_load latches gain into a pending register in any state; a later load overwrites it. Arbitration: a gain load is served only in IDLE, and it wins over an arm in the same cycle. An arm that loses is dropped.
- GAIN: 1 cycle; assert amp_start, drive amp_gain; go to GAIN_WAIT.
- GAIN_WAIT: when amp_busy is low, go to IDLE; this takes at least 1 cycle after amp_start.
- Timer: down-counter. It reloads rate_div on reaching 0 and generates a tick at 0. It runs continuously in TICK_WAIT/CONV_WAIT.
- TICK_WAIT: on tick, pulse conv_start and go to CONV_WAIT.
- CONV_WAIT: on conv_done, write the sample to the holding register if it is empty. Otherwise drop the sample and set overrun. Either way decrement the remaining count. If the count reaches 0, go to DRAIN; otherwise go to TICK_WAIT.
- A tick while in CONV_WAIT sets overrun and skips that slot; it does not count as a sample.
- first_flag = 1 only on the first sample of a capture.
- Holding register: out_valid is high while full. The word is accepted on out_valid && out_ready. A write and an accept in the same cycle leaves the register full with the new word.
- DRAIN: when out_valid == 0, pulse done and go to IDLE.
- abort in any non-IDLE state: next state IDLE, holding register cleared, no done. A conv_done received in IDLE is ignored. Abort does not interrupt an in-flight GAIN_WAIT; it waits for amp_busy low.

## Timing
- Reset values: state IDLE, amp_start 0, amp_gain 0x00, conv_start 0, out_valid 0, out_data 0, busy 0, done 0, overrun 0, pending gain cleared.
- All outputs are registered.
- First conv_start occurs 1 cycle after the arm cycle. Later conv_start pulses come every rate_div+1 cycles, provided conv_done returns in time.
- out_valid rises the cycle after conv_done.
- done comes 1 cycle after the last word is accepted; if the register is already empty, 1 cycle after the last conv_done.

## Configuration
- SCOPE_ACQ_TIMEOUT_EN defined: an 8-bit watchdog starts at conv_start or amp_start. If conv_done or amp_busy-low has not arrived after 255 cycles: go to IDLE, set overrun, no done.
- SCOPE_ACQ_TIMEOUT_EN undefined: no watchdog; the block waits indefinitely in CONV_WAIT/GAIN_WAIT.

## Test plan
- Reset mid-capture with out_valid=1 -> all outputs return to reset values immediately; overrun=0.
- gain_load gain=0x11 in IDLE, amp_busy high 20 cycles -> one amp_start; amp_gain=0x11 held; busy for 22 cycles.
- arm, rate_div=9, num_samples=4, conv_done 3 cycles after each start, out_ready=1 -> conv_start at cycles 1, 11, 21, 31; four words, first with bit15=1; done once; overrun=0.
- Same capture with out_ready=0 -> first word held, 3 dropped, overrun=1; done only after out_ready rises.
- rate_div=2, conv_done 5 cycles after start -> overrun=1, skipped slots produce no conv_start; 3 samples still counted.
- gain_load during capture -> no amp_start until after done, then one amp_start; abort mid-capture -> IDLE next cycle, no done, late conv_done ignored.
